// File: rtl/block_transfer_sequencer.sv
// Block transfer sequencer for LDM/STM: walks a register list lowest-first,
// issues one memory word access per register, writes loaded words into the
// register file and optionally writes back the updated base register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for START; operands captured on acceptance
// S_XFER   | memory access for lowest pending register, held until ready
// S_LOADWB | register-file write of the word just loaded
// S_BASEWB | register-file write of the updated base register
// S_DONE   | one-cycle completion pulse
module block_transfer_sequencer (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        L,
  input  logic        U,
  input  logic        P,
  input  logic        W,
  input  logic [3:0]  RN,
  input  logic [15:0] REG_LIST,
  input  logic [31:0] BASE,
  input  logic [31:0] MEM_DATA_IN,
  input  logic        MEM_READY,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [3:0]  RC,
  output logic [31:0] PW,
  output logic [3:0]  RW,
  output logic        E,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_XFER   = 3'd1,
    S_LOADWB = 3'd2,
    S_BASEWB = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;

  // captured operation context, stable until the block returns to idle
  logic        l_q;
  logic        do_wb_q;
  logic [3:0]  rn_q;
  logic [31:0] wb_q;
  logic [15:0] pending_q;
  logic [31:0] addr_q;
  logic [31:0] load_data_q;
  logic [3:0]  load_k_q;

  // control strobes from the next-state logic into the datapath
  logic        capture;
  logic        advance;
  logic        load_cap;

  // start-of-operation arithmetic on the live inputs
  logic [4:0]  n_in;
  logic [31:0] span;
  logic [31:0] a0;
  logic [31:0] wb_val;
  logic        do_wb_in;

  // lowest pending register and the list with it removed
  logic [3:0]  k;
  logic [15:0] pending_clr;
  logic        last;

  // Count the registers in the request and derive start address and writeback.
  always_comb begin
    n_in = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n_in = n_in + {4'd0, REG_LIST[i]};
    end
    span = {25'd0, n_in, 2'b00};
    case ({U, P})
      2'b10:   a0 = BASE;
      2'b11:   a0 = BASE + 32'd4;
      2'b00:   a0 = BASE - span + 32'd4;
      default: a0 = BASE - span;
    endcase
    wb_val = U ? (BASE + span) : (BASE - span);
    // a load that includes the base register lets the loaded value win
    do_wb_in = W & ~(L & REG_LIST[RN]);
  end

  // Priority-encode the lowest pending register.
  always_comb begin
    k = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pending_q[i]) k = 4'(i);
    end
    pending_clr = pending_q & ~(16'd1 << k);
    last        = (pending_clr == 16'd0);
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    advance  = 1'b0;
    load_cap = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          capture = 1'b1;
          state_d = (n_in == 5'd0) ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        if (MEM_READY) begin
          advance = 1'b1;
          if (l_q) begin
            load_cap = 1'b1;
            state_d  = S_LOADWB;
          end else if (last) begin
            state_d = do_wb_q ? S_BASEWB : S_DONE;
          end else begin
            state_d = S_XFER;
          end
        end
      end
      S_LOADWB: begin
        if (pending_q == 16'd0) state_d = do_wb_q ? S_BASEWB : S_DONE;
        else                    state_d = S_XFER;
      end
      S_BASEWB: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Operation context: captured on start, list/address stepped per access.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      l_q         <= 1'b0;
      do_wb_q     <= 1'b0;
      rn_q        <= 4'd0;
      wb_q        <= 32'd0;
      pending_q   <= 16'd0;
      addr_q      <= 32'd0;
      load_data_q <= 32'd0;
      load_k_q    <= 4'd0;
    end else begin
      if (capture) begin
        l_q       <= L;
        do_wb_q   <= do_wb_in;
        rn_q      <= RN;
        wb_q      <= wb_val;
        pending_q <= REG_LIST;
        addr_q    <= a0 & 32'hFFFF_FFFC;
      end else if (advance) begin
        pending_q <= pending_clr;
        addr_q    <= addr_q + 32'd4;
      end
      if (load_cap) begin
        load_data_q <= MEM_DATA_IN;
        load_k_q    <= k;
      end
    end
  end

  // Outputs decoded from state and registered context only, so a reset drops
  // every strobe immediately and nothing depends on MEM_READY or MEM_DATA_IN.
  always_comb begin
    MEM_ADDR = 32'd0;
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;
    RC       = 4'd0;
    PW       = 32'd0;
    RW       = 4'd0;
    E        = 1'b0;
    DONE     = 1'b0;
    BUSY     = (state_q != S_IDLE);
    case (state_q)
      S_XFER: begin
        MEM_ADDR = addr_q;
        MEM_RD   = l_q;
        MEM_WR   = ~l_q;
        RC       = k;
      end
      S_LOADWB: begin
        E  = 1'b1;
        RW = load_k_q;
        PW = load_data_q;
      end
      S_BASEWB: begin
        E  = 1'b1;
        RW = rn_q;
        PW = wb_q;
      end
      S_DONE:  DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Self-checking bench for block_transfer_sequencer: a vector table of block
// transfers plus hand-written wait-state, busy-START and reset sequences.
// Memory and register-file events are checked against a scoreboard queue.
module tb_block_transfer_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic        L = 1'b0;
  logic        U = 1'b0;
  logic        P = 1'b0;
  logic        W = 1'b0;
  logic [3:0]  RN = 4'd0;
  logic [15:0] REG_LIST = 16'd0;
  logic [31:0] BASE = 32'd0;
  logic [31:0] MEM_DATA_IN;
  logic        MEM_READY = 1'b1;
  logic [31:0] MEM_ADDR;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [3:0]  RC;
  logic [31:0] PW;
  logic [3:0]  RW;
  logic        E;
  logic        BUSY;
  logic        DONE;

  localparam logic [31:0] MEM_KEY = 32'hA5A5_5A5A;

  block_transfer_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .L(L), .U(U), .P(P), .W(W),
    .RN(RN), .REG_LIST(REG_LIST), .BASE(BASE), .MEM_DATA_IN(MEM_DATA_IN),
    .MEM_READY(MEM_READY), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
    .MEM_WR(MEM_WR), .RC(RC), .PW(PW), .RW(RW), .E(E), .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // memory returns a word that is a fixed function of its address
  assign MEM_DATA_IN = MEM_ADDR ^ MEM_KEY;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ MEM_KEY;
  endfunction

  typedef struct {
    bit          rf;
    bit          rd;
    logic [31:0] addr;
    logic [3:0]  rg;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    bit          l, u, p, w;
    logic [3:0]  rn;
    logic [15:0] list;
    logic [31:0] base;
    logic [31:0] exp_a0;
    bit          exp_wb_en;
    logic [31:0] exp_wb;
    int          exp_cycles;
  } vec_t;

  ev_t  sb[$];
  ev_t  mon_e;
  vec_t tbl[9];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_expected(input bit l, input logic [15:0] list, input logic [31:0] a0,
                               input bit wb_en, input logic [3:0] rn, input logic [31:0] wb);
    logic [31:0] a;
    ev_t e;
    a = a0;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        e.rf = 1'b0; e.rd = l; e.addr = a; e.rg = 4'(i); e.data = 32'd0;
        sb.push_back(e);
        if (l) begin
          e.rf = 1'b1; e.rd = 1'b0; e.addr = 32'd0; e.rg = 4'(i); e.data = mem_word(a);
          sb.push_back(e);
        end
        a = a + 32'd4;
      end
    end
    if (wb_en) begin
      e.rf = 1'b1; e.rd = 1'b0; e.addr = 32'd0; e.rg = rn; e.data = wb;
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor: every completed access and every register write pops one event.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (MEM_RD || MEM_WR) chk1("strobe exclusive", MEM_RD & MEM_WR, 1'b0);
      if ((MEM_RD || MEM_WR) && MEM_READY) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected access: addr %h rd %b", MEM_ADDR, MEM_RD);
        end else begin
          mon_e = sb.pop_front();
          chk1("event is access", 1'b0, mon_e.rf);
          chk32("mem_addr", MEM_ADDR, mon_e.addr);
          chk1("mem_rd", MEM_RD, mon_e.rd);
          chk32("rc", 32'(RC), 32'(mon_e.rg));
        end
      end
      if (E) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected rf write: rw %h pw %h", RW, PW);
        end else begin
          mon_e = sb.pop_front();
          chk1("event is rf write", 1'b1, mon_e.rf);
          chk32("rw", 32'(RW), 32'(mon_e.rg));
          chk32("pw", PW, mon_e.data);
        end
      end
    end
  end

  task automatic drive_op(input bit l, input bit u, input bit p, input bit w,
                          input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base);
    L = l; U = u; P = p; W = w; RN = rn; REG_LIST = list; BASE = base;
  endtask

  // START is raised just after an edge so it is sampled at the following edge (t0).
  task automatic start_op();
    @(posedge CLK); #1;
    chk1("idle before start", BUSY, 1'b0);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (DONE) got = 1'b1;
    end
  endtask

  task automatic run_vec(input int idx);
    int cyc;
    bit got;
    vec_t v;
    v = tbl[idx];
    push_expected(v.l, v.list, v.exp_a0, v.exp_wb_en, v.rn, v.exp_wb);
    drive_op(v.l, v.u, v.p, v.w, v.rn, v.list, v.base);
    start_op();
    chk1($sformatf("v%0d busy", idx), BUSY, 1'b1);
    wait_done(cyc, got);
    chk1($sformatf("v%0d done seen", idx), got, 1'b1);
    chk_int($sformatf("v%0d cycles", idx), cyc, v.exp_cycles);
    chk_int($sformatf("v%0d events left", idx), sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  got;
    int  total;

    //              l  u  p  w  rn     list      base          a0            wb_en wb           cycles
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 16'h000F, 32'h0000_0100, 32'h0000_0100, 1'b1, 32'h0000_0110, 6};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  16'h8010, 32'h0000_0200, 32'h0000_01F8, 1'b0, 32'h0,         5};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  16'h0004, 32'h0000_0300, 32'h0000_0300, 1'b0, 32'h0,         3};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0007, 32'h0000_0004, 32'hFFFF_FFFC, 1'b0, 32'h0,         4};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd1,  16'h0101, 32'h0000_1000, 32'h0000_1004, 1'b1, 32'h0000_1008, 6};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  16'hFFFF, 32'h8000_0000, 32'h7FFF_FFC0, 1'b1, 32'h7FFF_FFC0, 18};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd4,  16'h0000, 32'h0000_0900, 32'h0,         1'b0, 32'h0,         1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd5,  16'h0030, 32'h0000_0040, 32'h0000_003C, 1'b0, 32'h0,         5};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd3,  16'h0001, 32'h0000_0103, 32'h0000_0100, 1'b1, 32'h0000_0107, 3};

    // reset state
    #12;
    chk32("reset mem_addr", MEM_ADDR, 32'd0);
    chk1("reset mem_rd", MEM_RD, 1'b0);
    chk1("reset mem_wr", MEM_WR, 1'b0);
    chk32("reset rc", 32'(RC), 32'd0);
    chk32("reset pw", PW, 32'd0);
    chk32("reset rw", 32'(RW), 32'd0);
    chk1("reset e", E, 1'b0);
    chk1("reset busy", BUSY, 1'b0);
    chk1("reset done", DONE, 1'b0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    // table of transfers, run back to back (START in the cycle after DONE)
    for (int i = 0; i < 9; i++) run_vec(i);

    // wait states: second access stalls for three cycles
    push_expected(1'b0, 16'h0006, 32'h0000_0500, 1'b0, 4'd0, 32'd0);
    drive_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0006, 32'h0000_0500);
    start_op();
    @(negedge CLK);
    @(posedge CLK); #1;
    MEM_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk32("stall addr held", MEM_ADDR, 32'h0000_0504);
      chk1("stall wr held", MEM_WR, 1'b1);
      chk32("stall rc held", 32'(RC), 32'd2);
    end
    @(posedge CLK); #1;
    MEM_READY = 1'b1;
    @(negedge CLK);
    chk32("stall addr final", MEM_ADDR, 32'h0000_0504);
    wait_done(cyc, got);
    total = 5 + cyc;
    chk1("stall done seen", got, 1'b1);
    chk_int("stall cycles", total, 6);
    chk_int("stall events left", sb.size(), 0);
    sb.delete();

    // START pulsed while busy is ignored
    push_expected(1'b0, 16'h0003, 32'h0000_0600, 1'b0, 4'd0, 32'd0);
    drive_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0003, 32'h0000_0600);
    start_op();
    @(posedge CLK); #1;
    drive_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 16'hFFFF, 32'h0000_0000);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(cyc, got);
    total = 2 + cyc;
    chk1("busy start done seen", got, 1'b1);
    chk_int("busy start cycles", total, 3);
    chk_int("busy start events left", sb.size(), 0);
    sb.delete();
    @(negedge CLK);
    chk1("busy start back idle", BUSY, 1'b0);

    // reset during the second register-file write of a load
    push_expected(1'b1, 16'h0003, 32'h0000_0700, 1'b0, 4'd0, 32'd0);
    drive_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 16'h0003, 32'h0000_0700);
    start_op();
    for (int i = 0; i < 4; i++) @(negedge CLK);
    chk1("pre-reset e", E, 1'b1);
    chk32("pre-reset rw", 32'(RW), 32'd1);
    #1;
    RESET_N = 1'b0;
    #1;
    chk32("abort mem_addr", MEM_ADDR, 32'd0);
    chk1("abort mem_rd", MEM_RD, 1'b0);
    chk1("abort mem_wr", MEM_WR, 1'b0);
    chk32("abort rc", 32'(RC), 32'd0);
    chk32("abort pw", PW, 32'd0);
    chk32("abort rw", 32'(RW), 32'd0);
    chk1("abort e", E, 1'b0);
    chk1("abort busy", BUSY, 1'b0);
    chk1("abort done", DONE, 1'b0);
    chk_int("abort events left", sb.size(), 0);
    sb.delete();
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(negedge CLK);
    chk1("post-reset e", E, 1'b0);
    chk1("post-reset busy", BUSY, 1'b0);
    run_vec(0);
    run_vec(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
